steelhorse_rx_ring: RTL and testbench

Receive-side packet buffer directly downstream of the Steelhorse MAC. It captures the 32-bit words Steelhorse writes through DATA_ADDR/DATA_RECV/WRITE_DATA_RECV into a ring of fixed-size packet slots. On NWPCKT_IRQ_VALID it commits the slot together with the packet length into a descriptor queue. The host side pops descriptors and reads slot contents through a registered read port, which frees slots for reuse.

---
 rtl/steelhorse_rx_ring_pkg.sv | 27 ++
 rtl/steelhorse_rx_ring_if.sv | 42 ++++
 rtl/steelhorse_rx_ring_ram.sv | 27 ++
 rtl/steelhorse_rx_ring.sv | 166 ++++++++++++++++
 tb/tb_steelhorse_rx_ring.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/steelhorse_rx_ring_pkg.sv
// Shared definitions for the Steelhorse receive ring: MAC address layout and
// the descriptor record committed for every accepted packet.
package steelhorse_pkg;

  localparam int SEND_REGION_BIT = 9;
  localparam int MAC_ADDR_W      = 10;
  localparam int LEN_W           = 16;
  localparam int MAX_SLOT_W      = 8;

  typedef struct packed {
    logic [MAX_SLOT_W-1:0] slot;
    logic [LEN_W-1:0]      len;
    logic                  trunc;
  } desc_t;

  // A packet is truncated when it carries more bytes than one slot can hold.
  function automatic desc_t makeDesc(input logic [MAX_SLOT_W-1:0] slot,
                                     input logic [LEN_W-1:0]      len,
                                     input int                    slotAw);
    desc_t d;
    d.slot  = slot;
    d.len   = len;
    d.trunc = (32'(len) > (32'd4 << slotAw));
    return d;
  endfunction

endpackage

// File: rtl/steelhorse_rx_ring_if.sv
// Bus bundle of the receive ring: MAC capture inputs, descriptor queue head,
// host read port and status. The master side drives the MAC and host inputs.
interface steelhorse_rx_ring_if
  import steelhorse_pkg::*;
#(
  parameter int SLOTS   = 4,
  parameter int SLOT_AW = 7,
  parameter int DROP_W  = 8
) ();

  localparam int SW = $clog2(SLOTS);

  logic [MAC_ADDR_W-1:0] DATA_ADDR;
  logic [31:0]           DATA_RECV;
  logic                  WRITE_DATA_RECV;
  logic                  NWPCKT_IRQ_VALID;
  logic [LEN_W-1:0]      RECV_LEN;

  logic                  DESC_VALID;
  logic [SW-1:0]         DESC_SLOT;
  logic [LEN_W-1:0]      DESC_LEN;
  logic                  DESC_TRUNC;
  logic                  DESC_POP;

  logic [SW+SLOT_AW-1:0] HOST_ADDR;
  logic [31:0]           HOST_DATA;
  logic [DROP_W-1:0]     DROP_CNT;
  logic                  FULL;

  modport master (
    output DATA_ADDR, DATA_RECV, WRITE_DATA_RECV, NWPCKT_IRQ_VALID, RECV_LEN,
    output DESC_POP, HOST_ADDR,
    input  DESC_VALID, DESC_SLOT, DESC_LEN, DESC_TRUNC, HOST_DATA, DROP_CNT, FULL
  );

  modport slave (
    input  DATA_ADDR, DATA_RECV, WRITE_DATA_RECV, NWPCKT_IRQ_VALID, RECV_LEN,
    input  DESC_POP, HOST_ADDR,
    output DESC_VALID, DESC_SLOT, DESC_LEN, DESC_TRUNC, HOST_DATA, DROP_CNT, FULL
  );

endinterface

// File: rtl/steelhorse_rx_ring_ram.sv
// Simple dual-port packet RAM: one write port, one registered read port.
// Contents are never reset.
module rx_ring_ram #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [1<<AW];
  logic [DW-1:0] rdData_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rdData_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rdData_q;

endmodule

// File: rtl/steelhorse_rx_ring.sv
// Receive-side packet ring behind the Steelhorse MAC: captures MAC words into
// fixed-size slots, queues a descriptor per packet and serves host reads.
module steelhorse_rx_ring
  import steelhorse_pkg::*;
#(
  parameter int SLOTS   = 4,
  parameter int SLOT_AW = 7,
  parameter int DROP_W  = 8
) (
  input  logic CLK,
  input  logic RST,
  steelhorse_rx_ring_if.slave bus
);

  localparam int SW     = $clog2(SLOTS);
  localparam int CW     = SW + 1;
  localparam int RAM_AW = SW + SLOT_AW;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] DROP = 1'b1;

  localparam logic [CW-1:0] SLOTS_CNT = CW'(SLOTS);

  logic [0:0]         state_q, state_d;
  logic [SW-1:0]      wrSlot_q, wrSlot_d;
  logic [SW-1:0]      rdSlot_q, rdSlot_d;
  logic [CW-1:0]      count_q, count_d;
  logic [DROP_W-1:0]  dropCnt_q, dropCnt_d;

  logic               strobe_q;
  logic               sendRegion_q;
  logic [SLOT_AW-1:0] word_q;
  logic [31:0]        data_q;

  desc_t              descMem_q [SLOTS];
  desc_t              headDesc;
  logic               hostValid_q;
  logic [31:0]        ramRdData;

  logic               strobeFall;
  logic               ramWrEn;
  logic               doCommit;
  logic               doDrop;
  logic               doPop;
  logic               unusedBits;

  // The MAC word is committed to RAM on the strobe's falling edge, so keep the
  // last strobed address/data until then.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      strobe_q     <= 1'b0;
      sendRegion_q <= 1'b0;
      word_q       <= '0;
      data_q       <= '0;
    end else begin
      strobe_q <= bus.WRITE_DATA_RECV;
      if (bus.WRITE_DATA_RECV) begin
        sendRegion_q <= bus.DATA_ADDR[SEND_REGION_BIT];
        word_q       <= bus.DATA_ADDR[SLOT_AW-1:0];
        data_q       <= bus.DATA_RECV;
      end
    end
  end

  assign strobeFall = strobe_q & ~bus.WRITE_DATA_RECV;
  assign ramWrEn    = strobeFall && (state_q == FILL) && !sendRegion_q;
  assign doCommit   = (state_q == FILL) && bus.NWPCKT_IRQ_VALID && (bus.RECV_LEN != '0);
  assign doDrop     = (state_q == DROP) && bus.NWPCKT_IRQ_VALID;
  assign doPop      = bus.DESC_POP && (count_q != '0);

  // Slot pointers wrap naturally because SLOTS is a power of two.
  always_comb begin
    state_d   = state_q;
    wrSlot_d  = wrSlot_q;
    rdSlot_d  = rdSlot_q;
    count_d   = count_q;
    dropCnt_d = dropCnt_q;

    if (doCommit) begin
      wrSlot_d = wrSlot_q + SW'(1);
    end
    if (doPop) begin
      rdSlot_d = rdSlot_q + SW'(1);
    end

    case ({doCommit, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (doDrop && (dropCnt_q != '1)) begin
      dropCnt_d = dropCnt_q + DROP_W'(1);
    end

    case (state_q)
      FILL: begin
        if (doCommit && (count_d == SLOTS_CNT)) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (count_q < SLOTS_CNT) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= FILL;
      wrSlot_q    <= '0;
      rdSlot_q    <= '0;
      count_q     <= '0;
      dropCnt_q   <= '0;
      hostValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wrSlot_q    <= wrSlot_d;
      rdSlot_q    <= rdSlot_d;
      count_q     <= count_d;
      dropCnt_q   <= dropCnt_d;
      hostValid_q <= 1'b1;
    end
  end

  // Descriptors are stored at the index of their own slot, so the queue head
  // is always the entry addressed by the read slot pointer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < SLOTS; i++) begin
        descMem_q[i] <= '0;
      end
    end else if (doCommit) begin
      descMem_q[wrSlot_q] <= makeDesc(MAX_SLOT_W'(wrSlot_q), bus.RECV_LEN, SLOT_AW);
    end
  end

  assign headDesc = descMem_q[rdSlot_q];

  rx_ring_ram #(
    .AW (RAM_AW),
    .DW (32)
  ) u_ram (
    .clk_i     (CLK),
    .wr_en_i   (ramWrEn),
    .wr_addr_i ({wrSlot_q, word_q}),
    .wr_data_i (data_q),
    .rd_addr_i (bus.HOST_ADDR),
    .rd_data_o (ramRdData)
  );

  assign bus.DESC_VALID = (count_q != '0);
  assign bus.DESC_SLOT  = headDesc.slot[SW-1:0];
  assign bus.DESC_LEN   = headDesc.len;
  assign bus.DESC_TRUNC = headDesc.trunc;
  assign bus.FULL       = (count_q == SLOTS_CNT);
  assign bus.DROP_CNT   = dropCnt_q;
  // The RAM read register has no reset; mask it until the first clock after reset.
  assign bus.HOST_DATA  = hostValid_q ? ramRdData : 32'h0;

  assign unusedBits = ^{headDesc.slot[MAX_SLOT_W-1:SW], bus.DATA_ADDR[MAC_ADDR_W-2:SLOT_AW]};

endmodule

// File: tb/tb_steelhorse_rx_ring.sv
// Self-checking bench for steelhorse_rx_ring: directed scenarios with literal
// expectations plus a randomized phase checked against a queue-based model.
module tb_steelhorse_rx_ring;
  import steelhorse_pkg::*;

  localparam int SLOTS      = 4;
  localparam int SLOT_AW    = 7;
  localparam int DROP_W     = 8;
  localparam int WORDS      = SLOTS << SLOT_AW;
  localparam int SLOT_BYTES = 4 << SLOT_AW;
  localparam int DROP_MAX   = (1 << DROP_W) - 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  steelhorse_rx_ring_if #(.SLOTS(SLOTS), .SLOT_AW(SLOT_AW), .DROP_W(DROP_W)) bus ();

  steelhorse_rx_ring #(.SLOTS(SLOTS), .SLOT_AW(SLOT_AW), .DROP_W(DROP_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  typedef struct {
    int slot;
    int len;
    bit trunc;
  } mdesc_t;

  mdesc_t      modelQ[$];
  logic [31:0] modelMem [WORDS];
  bit          known [WORDS];
  int          modelWrSlot   = 0;
  bit          modelDropping = 0;
  int          modelDropCnt  = 0;
  bit          prevStrobe    = 0;
  logic [9:0]  latAddr       = '0;
  logic [31:0] latData       = '0;
  bit          hostExpValid  = 1;
  logic [31:0] hostExp       = '0;

  int          checks = 0;
  int          errors = 0;
  bit          randomHost = 0;
  logic [8:0]  tbHostAddr = '0;

  function automatic bit slotOwned(input int s);
    foreach (modelQ[i]) begin
      if (modelQ[i].slot == s) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Reference model: advances once per clock from the inputs the bench drove.
  always @(posedge CLK or negedge RST) begin
    int  sizeStart;
    int  haddr;
    int  idx;
    bit  popNow;
    mdesc_t d;
    if (!RST) begin
      modelQ.delete();
      modelWrSlot   = 0;
      modelDropping = 0;
      modelDropCnt  = 0;
      prevStrobe    = 0;
      hostExpValid  = 1;
      hostExp       = '0;
    end else begin
      sizeStart    = modelQ.size();
      haddr        = int'(bus.HOST_ADDR);
      hostExpValid = known[haddr] && slotOwned(haddr >> SLOT_AW);
      hostExp      = modelMem[haddr];
      if (prevStrobe && !bus.WRITE_DATA_RECV && !modelDropping && !latAddr[9]) begin
        idx = modelWrSlot * (1 << SLOT_AW) + int'(latAddr[SLOT_AW-1:0]);
        modelMem[idx] = latData;
        known[idx]    = 1'b1;
      end
      if (bus.WRITE_DATA_RECV) begin
        latAddr = bus.DATA_ADDR;
        latData = bus.DATA_RECV;
      end
      prevStrobe = bus.WRITE_DATA_RECV;
      popNow = bus.DESC_POP && (sizeStart > 0);
      if (bus.NWPCKT_IRQ_VALID) begin
        if (modelDropping) begin
          if (modelDropCnt < DROP_MAX) modelDropCnt++;
        end else if (bus.RECV_LEN != 16'h0) begin
          d.slot  = modelWrSlot;
          d.len   = int'(bus.RECV_LEN);
          d.trunc = (d.len > SLOT_BYTES);
          modelQ.push_back(d);
          modelWrSlot = (modelWrSlot + 1) % SLOTS;
        end
      end
      if (popNow) void'(modelQ.pop_front());
      if (modelDropping) begin
        if (sizeStart < SLOTS) modelDropping = 0;
      end else if (modelQ.size() == SLOTS) begin
        modelDropping = 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Every cycle the DUT outputs must agree with the model.
  always @(negedge CLK) begin
    checkOutput("desc_valid", 32'(bus.DESC_VALID), 32'(modelQ.size() != 0));
    checkOutput("full", 32'(bus.FULL), 32'(modelQ.size() == SLOTS));
    checkOutput("drop_cnt", 32'(bus.DROP_CNT), 32'(modelDropCnt));
    if (modelQ.size() != 0) begin
      checkOutput("desc_slot", 32'(bus.DESC_SLOT), 32'(modelQ[0].slot));
      checkOutput("desc_len", 32'(bus.DESC_LEN), 32'(modelQ[0].len));
      checkOutput("desc_trunc", 32'(bus.DESC_TRUNC), 32'(modelQ[0].trunc));
    end
    if (hostExpValid) begin
      checkOutput("host_data", bus.HOST_DATA, hostExp);
    end
  end

  task automatic applyStimulus(input logic strobe, input logic [9:0] addr,
                               input logic [31:0] data, input logic irq,
                               input logic [15:0] len, input logic pop);
    bus.WRITE_DATA_RECV  = strobe;
    bus.DATA_ADDR        = addr;
    bus.DATA_RECV        = data;
    bus.NWPCKT_IRQ_VALID = irq;
    bus.RECV_LEN         = len;
    bus.DESC_POP         = pop;
    bus.HOST_ADDR        = randomHost ? 9'($urandom_range(0, WORDS - 1)) : tbHostAddr;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 10'h0, 32'h0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic sendWord(input logic [9:0] addr, input logic [31:0] data,
                          input int hi, input int lo);
    repeat (hi) applyStimulus(1'b1, addr, data, 1'b0, 16'h0, 1'b0);
    repeat (lo) applyStimulus(1'b0, addr, data, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic sendIrq(input logic [15:0] len, input logic pop);
    applyStimulus(1'b0, 10'h0, 32'h0, 1'b1, len, pop);
  endtask

  task automatic popDesc();
    applyStimulus(1'b0, 10'h0, 32'h0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic doReset();
    bus.WRITE_DATA_RECV  = 1'b0;
    bus.NWPCKT_IRQ_VALID = 1'b0;
    bus.DESC_POP         = 1'b0;
    bus.RECV_LEN         = 16'h0;
    #2 RST = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic sendRandomPacket();
    int          nw;
    logic [9:0]  addr;
    logic [15:0] len;
    int          r;
    nw = $urandom_range(0, 4);
    for (int i = 0; i < nw; i++) begin
      addr = 10'($urandom_range(0, 511));
      if ($urandom_range(0, 9) == 0) addr[9] = 1'b1;
      sendWord(addr, $urandom, $urandom_range(1, 3), $urandom_range(1, 3));
    end
    r = $urandom_range(0, 9);
    if (r < 2)      len = 16'h0;
    else if (r < 4) len = 16'($urandom_range(SLOT_BYTES + 1, 16'hffff));
    else            len = 16'($urandom_range(1, SLOT_BYTES));
    sendIrq(len, 1'($urandom_range(0, 3) == 0));
  endtask

  initial begin
    bus.WRITE_DATA_RECV  = 1'b0;
    bus.DATA_ADDR        = '0;
    bus.DATA_RECV        = '0;
    bus.NWPCKT_IRQ_VALID = 1'b0;
    bus.RECV_LEN         = '0;
    bus.DESC_POP         = 1'b0;
    bus.HOST_ADDR        = '0;

    #2 RST = 1'b0;
    @(negedge CLK);
    checkOutput("rst_desc_valid", 32'(bus.DESC_VALID), 32'd0);
    checkOutput("rst_desc_slot", 32'(bus.DESC_SLOT), 32'd0);
    checkOutput("rst_desc_len", 32'(bus.DESC_LEN), 32'd0);
    checkOutput("rst_desc_trunc", 32'(bus.DESC_TRUNC), 32'd0);
    checkOutput("rst_host_data", bus.HOST_DATA, 32'd0);
    checkOutput("rst_drop_cnt", 32'(bus.DROP_CNT), 32'd0);
    checkOutput("rst_full", 32'(bus.FULL), 32'd0);
    @(negedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);

    // Basic capture and descriptor commit.
    sendWord(10'h000, 32'h12345678, 2, 2);
    sendWord(10'h001, 32'h9abcdef0, 2, 2);
    sendWord(10'h002, 32'h01234567, 2, 2);
    sendWord(10'h003, 32'h89abcdef, 2, 2);
    sendIrq(16'h0010, 1'b0);
    checkOutput("s1_desc_valid", 32'(bus.DESC_VALID), 32'd1);
    checkOutput("s1_desc_slot", 32'(bus.DESC_SLOT), 32'd0);
    checkOutput("s1_desc_len", 32'(bus.DESC_LEN), 32'h10);
    checkOutput("s1_desc_trunc", 32'(bus.DESC_TRUNC), 32'd0);
    tbHostAddr = 9'h002;
    idle(1);
    checkOutput("s1_host_data", bus.HOST_DATA, 32'h01234567);

    // Ring full, drop counting, slot reuse after a pop.
    doReset();
    for (int i = 0; i < SLOTS; i++) begin
      sendWord(10'h000, 32'ha0000000 + 32'(i), 1, 1);
      sendIrq(16'h0004, 1'b0);
    end
    sendWord(10'h000, 32'hbad0bad0, 1, 1);
    sendIrq(16'h0004, 1'b0);
    checkOutput("s2_full", 32'(bus.FULL), 32'd1);
    checkOutput("s2_drop_cnt", 32'(bus.DROP_CNT), 32'd1);
    checkOutput("s2_head_slot", 32'(bus.DESC_SLOT), 32'd0);
    tbHostAddr = 9'h000;
    idle(1);
    checkOutput("s2_slot0_kept", bus.HOST_DATA, 32'ha0000000);
    popDesc();
    idle(2);
    sendWord(10'h000, 32'h66666666, 1, 1);
    sendIrq(16'h0004, 1'b0);
    checkOutput("s2_refull", 32'(bus.FULL), 32'd1);
    checkOutput("s2_drop_stays", 32'(bus.DROP_CNT), 32'd1);
    repeat (3) popDesc();
    checkOutput("s2_reuse_slot", 32'(bus.DESC_SLOT), 32'd0);
    idle(1);
    checkOutput("s2_reuse_data", bus.HOST_DATA, 32'h66666666);

    // Drop counter saturates at all-ones.
    doReset();
    for (int i = 0; i < SLOTS; i++) sendIrq(16'h0004, 1'b0);
    repeat (DROP_MAX + 5) sendIrq(16'h0004, 1'b0);
    checkOutput("sat_drop_cnt", 32'(bus.DROP_CNT), 32'hff);

    // Send-region writes are ignored.
    doReset();
    sendWord(10'h200, 32'hdeadbeef, 1, 1);
    sendWord(10'h000, 32'hcafef00d, 1, 1);
    sendWord(10'h001, 32'h11111111, 1, 1);
    sendWord(10'h201, 32'hdeadbeef, 1, 1);
    sendIrq(16'h0008, 1'b0);
    tbHostAddr = 9'h000;
    idle(1);
    checkOutput("s3_word0", bus.HOST_DATA, 32'hcafef00d);
    tbHostAddr = 9'h001;
    idle(1);
    checkOutput("s3_word1", bus.HOST_DATA, 32'h11111111);

    // Commit and pop in the same cycle.
    doReset();
    sendIrq(16'h0004, 1'b0);
    sendIrq(16'h0004, 1'b0);
    sendIrq(16'h0004, 1'b1);
    checkOutput("s4_valid", 32'(bus.DESC_VALID), 32'd1);
    checkOutput("s4_full", 32'(bus.FULL), 32'd0);
    checkOutput("s4_head", 32'(bus.DESC_SLOT), 32'd1);
    popDesc();
    checkOutput("s4_head2", 32'(bus.DESC_SLOT), 32'd2);
    popDesc();
    checkOutput("s4_empty", 32'(bus.DESC_VALID), 32'd0);

    // Truncation boundary and zero-length packets.
    doReset();
    sendIrq(16'h0600, 1'b0);
    checkOutput("s5_trunc", 32'(bus.DESC_TRUNC), 32'd1);
    checkOutput("s5_len", 32'(bus.DESC_LEN), 32'h600);
    popDesc();
    sendIrq(16'h0000, 1'b0);
    checkOutput("s5_zero_len", 32'(bus.DESC_VALID), 32'd0);
    sendIrq(16'h0200, 1'b0);
    checkOutput("s5_exact_trunc", 32'(bus.DESC_TRUNC), 32'd0);
    checkOutput("s5_exact_slot", 32'(bus.DESC_SLOT), 32'd1);
    popDesc();
    sendIrq(16'h0201, 1'b0);
    checkOutput("s5_over_trunc", 32'(bus.DESC_TRUNC), 32'd1);

    // Reset in the middle of a packet.
    doReset();
    sendWord(10'h000, 32'h0000aaaa, 1, 1);
    sendWord(10'h001, 32'h0000bbbb, 1, 1);
    sendWord(10'h002, 32'h0000cccc, 1, 1);
    applyStimulus(1'b1, 10'h003, 32'h0000dddd, 1'b0, 16'h0, 1'b0);
    doReset();
    sendWord(10'h000, 32'h00000123, 1, 1);
    sendWord(10'h001, 32'h00000456, 1, 1);
    sendIrq(16'h0008, 1'b0);
    checkOutput("s6_slot", 32'(bus.DESC_SLOT), 32'd0);
    checkOutput("s6_len", 32'(bus.DESC_LEN), 32'h8);
    checkOutput("s6_drop", 32'(bus.DROP_CNT), 32'd0);
    popDesc();
    checkOutput("s6_single", 32'(bus.DESC_VALID), 32'd0);

    // Randomized traffic against the model.
    doReset();
    randomHost = 1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: sendRandomPacket();
        6, 7:             popDesc();
        default:          idle($urandom_range(1, 3));
      endcase
    end
    randomHost = 0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
